fetch_prefetch_unit: RTL

//  Parametrised instruction fetch stage with a prefetch queue and branch redirect.

---
 rtl/fetch_prefetch_unit.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_unit
//
// Instruction fetch stage with a prefetch queue and branch redirect. Keeps up
// to MAX_OUTSTANDING word reads in flight on a req/gnt memory port, buffers
// returned words in a DEPTH-entry FIFO and hands instructions to decode over
// a valid/ready handshake.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   stall               1 = no new request issued, no queue pop
//   redirect_valid/pc   branch/exception redirect strobe and byte target
//   mem_req/mem_addr    read request and word-aligned address
//   mem_gnt             request accepted this cycle when mem_req=1
//   mem_rvalid/rdata    in-order read return, at least one cycle after gnt
//   instr_valid/ready   handshake towards decode
//   instr/instr_pc      instruction and its byte address
//
// Build option
//   FETCH_HALFWORD_EN   16-bit instruction mode: each queued word yields
//                       DATA_WIDTH/16 big-endian halfwords, instr_pc steps
//                       by 2, and a redirect keeps its halfword offset.
// ---------------------------------------------------------------------------
module fetch_prefetch_unit #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DEPTH           = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
`ifdef FETCH_HALFWORD_EN
    localparam int                   IW              = 16
`else
    localparam int                   IW              = DATA_WIDTH
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [IW-1:0]         instr,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(BYTES - 1);
`ifdef FETCH_HALFWORD_EN
    localparam int HPW = DATA_WIDTH / 16;
    localparam logic [ADDR_WIDTH-1:0] REDIR_MASK = ~ADDR_WIDTH'(1);
`else
    localparam logic [ADDR_WIDTH-1:0] REDIR_MASK = WORD_MASK;
`endif
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(BYTES);
    localparam logic [CW-1:0]         FULL_C    = CW'(DEPTH);
    localparam logic [CW:0]           OCC_LIM   = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]         MAXO_C    = CW'(MAX_OUTSTANDING);

    // Control state (reset)
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] ret_pc_q,   ret_pc_d;    // pc of the next non-discarded return
    logic [CW-1:0]         count_q,    count_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         discard_q,  discard_d;
    logic [PW-1:0]         rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q,   wr_ptr_d;

    // Queue storage (not reset; qualified by count_q)
    logic [DATA_WIDTH-1:0] q_word_q [DEPTH];
    logic [DATA_WIDTH-1:0] q_word_d [DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc_d   [DEPTH];

    logic                  rvalid_eff, grant, push, pop, accept, hw_last, hw_step;
    logic [CW:0]           occ;
    logic [DATA_WIDTH-1:0] head_word;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [IW-1:0]         instr_sel;

    // Issue side: a free queue slot is reserved for every outstanding read
    // Returns arriving while nothing is outstanding (stale after reset) are ignored.
    assign rvalid_eff = mem_rvalid && (inflight_q != '0);
    assign occ        = {1'b0, count_q} + {1'b0, inflight_q};
    assign mem_req    = !reset && !stall && !redirect_valid &&
                        (inflight_q < MAXO_C) && (occ < OCC_LIM);
    assign mem_addr   = fetch_pc_q & WORD_MASK;
    assign grant      = mem_req && mem_gnt;

    // Output side: queue head
    assign head_word   = q_word_q[rd_ptr_q];
    assign head_pc     = q_pc_q[rd_ptr_q];
    assign instr_valid = (count_q != '0) && !stall;
    assign accept      = instr_valid && instr_ready;

`ifdef FETCH_HALFWORD_EN
    logic [OFF-2:0] hw_idx;
    assign hw_idx  = head_pc[OFF-1:1];
    assign hw_last = (hw_idx == {(OFF-1){1'b1}});

    // Halfword 0 (lowest address) sits in the most significant bits.
    always_comb begin
        instr_sel = '0;
        for (int k = 0; k < HPW; k++) begin
            if (hw_idx == (OFF-1)'(k)) begin
                instr_sel = head_word[DATA_WIDTH-1-16*k -: 16];
            end
        end
    end
`else
    assign hw_last   = 1'b1;
    assign instr_sel = head_word;
`endif

    assign instr    = (count_q != '0) ? instr_sel : '0;
    assign instr_pc = (count_q != '0) ? head_pc   : '0;

    assign push    = rvalid_eff && (discard_q == '0) && !redirect_valid;
    assign pop     = accept && hw_last && !redirect_valid;
    assign hw_step = accept && !hw_last && !redirect_valid;

    // Next-state
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        ret_pc_d   = ret_pc_q;
        count_d    = count_q;
        inflight_d = inflight_q + CW'(grant) - CW'(rvalid_eff);
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        q_word_d   = q_word_q;
        q_pc_d     = q_pc_q;

        if (redirect_valid) begin
            // Everything still outstanding after this cycle's return is stale.
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            discard_d  = inflight_q - CW'(rvalid_eff);
            fetch_pc_d = redirect_pc & REDIR_MASK;
            ret_pc_d   = redirect_pc & REDIR_MASK;
        end else begin
            if (grant) begin
                fetch_pc_d = (fetch_pc_q & WORD_MASK) + WORD_STEP;
            end
            if (rvalid_eff && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                q_word_d[wr_ptr_q] = mem_rdata;
                q_pc_d[wr_ptr_q]   = ret_pc_q;
                wr_ptr_d           = wr_ptr_q + PW'(1);
                ret_pc_d           = (ret_pc_q & WORD_MASK) + WORD_STEP;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else if (hw_step) begin
                // Partially consumed word: advance its pc in place.
                q_pc_d[rd_ptr_q] = head_pc + ADDR_WIDTH'(2);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC & REDIR_MASK;
            ret_pc_q   <= RESET_PC & REDIR_MASK;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ret_pc_q   <= ret_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        q_word_q <= q_word_d;
        q_pc_q   <= q_pc_d;
    end

    // The issue-side space check must make an overflowing push impossible.
    assert property (@(posedge clk) disable iff (reset) !(push && (count_q == FULL_C)));

endmodule
